// File: rtl/ins_mem_loader.sv
// Instruction RAM loader/reader feeding the SIMD decoder.
// Optional INS_LOADER_CHECKSUM_EN adds an XOR checksum check on load.
module ins_mem_loader #(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 3,
  localparam int INS_WIDTH     = OPCODE_WIDTH + 3 * ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      load_start,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [INS_WIDTH-1:0]      s_data,
  input  logic                      s_last,
  input  logic [INS_ADDR_WIDTH-1:0] pc,
  output logic [INS_WIDTH-1:0]      instruction,
  output logic                      ins_valid,
  output logic                      half_clk,
  output logic [INS_ADDR_WIDTH:0]   prog_len,
  output logic                      load_busy
`ifdef INS_LOADER_CHECKSUM_EN
  ,
  input  logic [INS_WIDTH-1:0]      exp_csum,
  output logic                      csum_err
`endif
);

  localparam int DEPTH = 2 ** INS_ADDR_WIDTH;
  localparam logic [INS_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [INS_ADDR_WIDTH:0]   LEN_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  state_t                    state;
  logic [INS_ADDR_WIDTH-1:0] wr_addr;
  logic [INS_WIDTH-1:0]      mem [DEPTH];
  logic                      accept;
  logic                      done;
  logic                      csum_ok;

  assign s_ready   = (state == LOAD);
  assign load_busy = (state == LOAD);
  assign ins_valid = (state == READY);
  assign accept    = s_valid && s_ready;
  assign done      = accept && (s_last || (&wr_addr));

`ifdef INS_LOADER_CHECKSUM_EN
  logic [INS_WIDTH-1:0] csum;

  assign csum_ok = ((csum ^ s_data) == exp_csum);

  // Running XOR of accepted words; error flag held until next load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      csum     <= '0;
      csum_err <= 1'b0;
    end else begin
      if (load_start && state != LOAD) begin
        csum <= '0;
      end else if (accept) begin
        csum <= csum ^ s_data;
      end
      if (load_start) begin
        csum_err <= 1'b0;
      end else if (done && !csum_ok) begin
        csum_err <= 1'b1;
      end
    end
  end
`else
  assign csum_ok = 1'b1;
`endif

  // Load-control state machine and program length.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      wr_addr  <= '0;
      prog_len <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state   <= LOAD;
            wr_addr <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_addr <= wr_addr + ADDR_ONE;
            if (done) begin
              prog_len <= {1'b0, wr_addr} + LEN_ONE;
              state    <= csum_ok ? READY : IDLE;
            end
          end
        end
        READY: begin
          if (load_start) begin
            state   <= LOAD;
            wr_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoder step enable, free-running out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      half_clk <= 1'b0;
    end else begin
      half_clk <= ~half_clk;
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (rstn && accept) begin
      mem[wr_addr] <= s_data;
    end
  end

  // Registered read, NOP outside READY or past the program end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instruction <= '0;
    end else if (state == READY && ({1'b0, pc} < prog_len)) begin
      instruction <= mem[pc];
    end else begin
      instruction <= '0;
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader: directed loads and reads,
// expected read data queued by stimulus and checked by a monitor.
module tb_ins_mem_loader;

  localparam int AW = 10;
  localparam int IW = 33;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          load_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [IW-1:0] instruction;
  logic          ins_valid;
  logic          half_clk;
  logic [AW:0]   prog_len;
  logic          load_busy;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [IW-1:0] exp_csum = '0;
  logic          csum_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [IW-1:0] exp_q[$];
  logic          rd_issue = 1'b0;
  logic          fire = 1'b0;

  ins_mem_loader dut (
    .clk(clk),
    .rstn(rstn),
    .load_start(load_start),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .pc(pc),
    .instruction(instruction),
    .ins_valid(ins_valid),
    .half_clk(half_clk),
    .prog_len(prog_len),
    .load_busy(load_busy)
`ifdef INS_LOADER_CHECKSUM_EN
    ,
    .exp_csum(exp_csum),
    .csum_err(csum_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Read issued at a negedge is captured at the next posedge.
  always @(posedge clk) fire <= rd_issue;

  // Monitor: pop and compare one expected word per completed read.
  always @(negedge clk) begin
    if (fire) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: got 0x%0h want none", instruction);
      end else begin
        logic [IW-1:0] e;
        e = exp_q.pop_front();
        if (instruction !== e) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%0h want 0x%0h", instruction, e);
        end
      end
    end
  end

  // Tasks are entered at a negedge and return at a negedge.
  task automatic rd(input logic [AW-1:0] p, input logic [IW-1:0] e);
    pc = p;
    exp_q.push_back(e);
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic l);
    chk("s_ready_beat", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic gap();
    s_data = 33'h0BAD;
    @(negedge clk);
  endtask

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("load_busy", 64'(load_busy), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("half_clk", 64'(half_clk), 64'(i % 2));
      chk("rst_instr", 64'(instruction), 64'd0);
      chk("rst_valid", 64'(ins_valid), 64'd0);
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_len", 64'(prog_len), 64'd0);
      @(negedge clk);
    end

    // Three-word program.
    start();
    beat(33'h1, 1'b0);
    beat(33'h2, 1'b0);
    beat(33'h3, 1'b1);
    chk("p3_valid", 64'(ins_valid), 64'd1);
    chk("p3_len", 64'(prog_len), 64'd3);
    chk("p3_ready", 64'(s_ready), 64'd0);
    rd(1, 33'h2);
    rd(5, 33'h0);
    rd(0, 33'h1);
    rd(2, 33'h3);
    rd(3, 33'h0);

    // Fill the RAM with no s_last.
    start();
    for (int i = 0; i < 1024; i++) beat(33'(i + 100), 1'b0);
    s_valid = 1'b1;
    s_data  = 33'h1FFFF;
    chk("full_ready", 64'(s_ready), 64'd0);
    chk("full_valid", 64'(ins_valid), 64'd1);
    chk("full_len", 64'(prog_len), 64'd1024);
    @(negedge clk);
    s_valid = 1'b0;
    rd(1023, 33'd1123);
    rd(0, 33'd100);
    rd(512, 33'd612);

    // Gapped stream: only valid beats land.
    start();
    beat(33'hA, 1'b0);
    gap();
    beat(33'hB, 1'b0);
    gap();
    beat(33'hC, 1'b1);
    chk("gap_len", 64'(prog_len), 64'd3);
    rd(0, 33'hA);
    rd(1, 33'hB);
    rd(2, 33'hC);
    rd(3, 33'h0);

    // Reload from READY; reads are NOP until done.
    start();
    chk("reload_valid", 64'(ins_valid), 64'd0);
    chk("reload_len", 64'(prog_len), 64'd3);
    rd(0, 33'h0);
    beat(33'h11, 1'b0);
    beat(33'h22, 1'b1);
    chk("reload_valid2", 64'(ins_valid), 64'd1);
    chk("reload_len2", 64'(prog_len), 64'd2);
    rd(1, 33'h22);
    rd(2, 33'h0);

    // Reset in the middle of a load.
    start();
    beat(33'h55, 1'b0);
    beat(33'h66, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("mid_valid", 64'(ins_valid), 64'd0);
    chk("mid_len", 64'(prog_len), 64'd0);
    chk("mid_ready", 64'(s_ready), 64'd0);
    rd(0, 33'h0);

`ifdef INS_LOADER_CHECKSUM_EN
    exp_csum = 33'h7;
    start();
    beat(33'h5, 1'b0);
    beat(33'h3, 1'b1);
    chk("csum_err", 64'(csum_err), 64'd1);
    chk("csum_idle", 64'(ins_valid), 64'd0);
    rd(0, 33'h0);
    exp_csum = 33'h6;
    start();
    chk("csum_clr", 64'(csum_err), 64'd0);
    beat(33'h5, 1'b0);
    beat(33'h3, 1'b1);
    chk("csum_ok", 64'(csum_err), 64'd0);
    chk("csum_ready", 64'(ins_valid), 64'd1);
    rd(1, 33'h3);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Instruction-memory stage directly upstream of the SIMD decoder.
- Accepts a program over a valid/ready stream, stores it in an internal instruction RAM, and returns the instruction at the decoder's pc with one-cycle registered latency.
- Generates the half_clk enable the decoder steps on. Holds ins_valid while a complete program is resident; the decoder wraps pc from all-ones to 0 only when ins_valid is high.
- Forces NOP (all zeros) while loading and for addresses beyond the loaded program length.

Parameters:
- INS_ADDR_WIDTH, 10, instruction RAM address width; depth = 2**INS_ADDR_WIDTH.
- ADDR_WIDTH, 10, data-memory address field width inside an instruction.
- OPCODE_WIDTH, 3, opcode field width.
- INS_WIDTH, OPCODE_WIDTH+3*ADDR_WIDTH, instruction word width (local, derived).

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- load_start  input  1  single-cycle request to begin (re)loading a program.
- s_valid  input  1  stream beat valid.
- s_ready  output  1  stream beat ready.
- s_data  input  INS_WIDTH  instruction word.
- s_last  input  1  final beat of the program.
- pc  input  INS_ADDR_WIDTH  read address from the decoder.
- instruction  output  INS_WIDTH  registered instruction to the decoder.
- ins_valid  output  1  complete program resident.
- half_clk  output  1  alternating-cycle step enable to the decoder.
- prog_len  output  INS_ADDR_WIDTH+1  number of loaded words (1..2**INS_ADDR_WIDTH).
- load_busy  output  1  high while in LOAD.

Behaviour:
- Reset (rstn low at a clk edge):
  - State goes to IDLE.
  - instruction=0, ins_valid=0, half_clk=0, prog_len=0, s_ready=0, load_busy=0.
  - Write pointer wr_addr=0.
  - RAM contents are not reset.
- half_clk: toggles every clk cycle out of reset; reads 1 on the second cycle after reset release. It is independent of state.
- States: IDLE, LOAD, READY.
- IDLE:
  - s_ready=0, ins_valid=0.
  - load_start=1 moves to LOAD with wr_addr=0.
- LOAD:
  - s_ready=1 and load_busy=1 (both combinational from state).
  - A beat is accepted when s_valid&&s_ready: mem[wr_addr]<=s_data, then wr_addr increments.
  - The load ends when the accepted beat has s_last=1 or wr_addr is all-ones (RAM full). On that beat, prog_len<=wr_addr+1 at full width and the state moves to READY.
  - A beat with s_last=1 arriving at the full address ends the load once, with prog_len=2**INS_ADDR_WIDTH.
  - Beats beyond the full address are never accepted, because s_ready drops in READY.
  - load_start during LOAD is ignored.
  - prog_len keeps its old value until the load completes.
- READY:
  - ins_valid=1, s_ready=0.
  - load_start=1 returns to LOAD with wr_addr=0. ins_valid reads 0 from the next cycle.
- Read path, every cycle:
  - instruction <= (state==READY && pc<prog_len) ? mem[pc] : 0.
  - Latency is one clk from pc to instruction. The decoder changes pc at most every second cycle, so the data is stable for a full half_clk period.
- Read/write collision: not possible, because reads are masked to NOP outside READY and writes occur only in LOAD.
- Reset mid-LOAD: the partial program is discarded, the state returns to IDLE, and ins_valid stays 0 until a full reload.
- Width rule: the pc<prog_len comparison is unsigned, with pc zero-extended to INS_ADDR_WIDTH+1.

Optional Feature:
- Macro: INS_LOADER_CHECKSUM_EN.
- When defined:
  - Adds input exp_csum [INS_WIDTH-1:0] and output csum_err (1 bit).
  - A running XOR of accepted s_data words is cleared on entry to LOAD.
  - The final XOR is compared to exp_csum on the completing beat.
  - On mismatch the state goes to IDLE instead of READY, csum_err=1, and ins_valid stays 0.
  - csum_err clears on reset or the next load_start.
- When not defined: no extra ports and no check.

Test Plan:
- Reset, then 4 cycles idle -> instruction=0, ins_valid=0, s_ready=0, and half_clk reads 0,1,0,1.
- load_start; stream words 0x1, 0x2, 0x3 with s_last on the third; then pc=1 -> prog_len=3, ins_valid=1 the cycle after the last beat, and instruction=0x2 one clk after pc=1.
- Same program with pc=5 -> instruction=0 (NOP padding because pc≥prog_len).
- Stream 2**INS_ADDR_WIDTH beats with s_valid held and no s_last -> all 1024 beats accepted, the 1025th is not (s_ready=0), prog_len=1024, and pc=1023 returns the last word.
- s_valid toggling 1,0,1,0 during LOAD -> only beats with s_valid=1 are written and wr_addr increments only on those. Reload via load_start in READY -> ins_valid=0 and instruction=0 until the new s_last.
- Reset asserted after 2 of 5 beats, then pc=0 -> ins_valid=0 and instruction=0. With INS_LOADER_CHECKSUM_EN: words 0x5, 0x3 with exp_csum=0x7 -> csum_err=1 and state IDLE; with exp_csum=0x6 -> READY.
